key_cmd_encoder: RTL and testbench
==================================

# key_cmd_encoder

Converts the USB keyboard's per-frame keycode pair into the 3-bit player command stream plus its `enabled` qualifier. It is the producing end of the player command interface. Each player gets one instance, with its own key map set by parameters, and it sits between the keyboard interface and the player block. The block holds a most-recently-pressed direction stack and generates one-shot bomb requests with a cooldown. It registers one command per frame_clk.

## Interface
- KEY_UP, default 8'h1A (W): HID code for the up direction.
- KEY_DOWN, default 8'h16 (S): HID code for the down direction.
- KEY_LEFT, default 8'h04 (A): HID code for the left direction.
- KEY_RIGHT, default 8'h07 (D): HID code for the right direction.
- KEY_BOMB, default 8'h2C (space): HID code for the bomb key.
- BOMB_COOLDOWN, default 8: number of frames after a set_bomb during which new bomb requests are ignored. Range 0–255.
- Ports:
  - Reset  in  1  asynchronous, active-high.
  - frame_clk  in  1  clock; one rising edge per video frame.
  - keycode0  in  8  first currently-held HID key; 8'h00 = none.
  - keycode1  in  8  second currently-held HID key; 8'h00 = none.
  - command  out  3  registered command: up=0, down=1, left=2, right=3, set_bomb=4, no_op=5.
  - enabled  out  1  registered; 1 only when command is 0–3.
  - bomb_pulse  out  1  registered; 1 exactly in frames where command=4.
- Reset and clock: reset is Reset, asynchronous, active-high; the clock is frame_clk.

## Operation
- **Held-key decode.** Each frame, build held[4:0] (up, down, left, right, bomb).
  - A key counts as held if either keycode matches its code.
  - The same code in both slots counts as one key.
  - Unmapped codes are ignored.
- **Registered state.** The block keeps prev_held[4:0], a 4-entry direction stack (2-bit id plus valid per entry; entry 0 is the top), and an 8-bit cooldown counter.
- **Edges.** press = held & ~prev_held; release = ~held & prev_held.
- **Stack update, per frame, in this order:**
  1. Remove every released direction, compacting the remaining entries toward the top and preserving their order.
  2. Push each pressed direction onto the top.
  3. If several directions are pressed in the same frame, push in the order right, left, down, up, so that up ends on top (fixed priority up > down > left > right).
  4. A direction never appears twice in the stack.
  5. The stack cannot overflow, since there are only 4 ids.
- **Command select, from post-update state.**
  1. If a bomb request fires this frame: command=4, enabled=0, bomb_pulse=1.
  2. Otherwise, if the stack top is valid: command = top id, enabled=1.
  3. Otherwise: command=5, enabled=0.
- **Bomb request fires** when press[bomb]=1 and cooldown=0.
  - Firing loads cooldown with BOMB_COOLDOWN.
  - Otherwise, if cooldown≠0, it decrements by 1.
  - A press edge that arrives during cooldown is dropped, not queued.
- **Opposing directions** (e.g. up+down held) are resolved by the stack: the most recently pressed wins; if both were pressed in the same frame, fixed priority decides.
- **Keycode 8'h00** in a slot contributes nothing.
- **Bomb-frame movement.** A movement direction that is held during a bomb frame stays in the stack and resumes the frame after.

## Timing
- Reset values:
  - command=5, enabled=0, bomb_pulse=0.
  - prev_held=0, stack all invalid, cooldown=0.
- Reset takes effect immediately and asynchronously, including mid-cooldown.
- Latency: keycodes sampled at frame_clk edge N are reflected on the outputs after edge N, so they are valid for the player's edge N+1. This is one frame of latency.
- All outputs come straight from registers; there is no combinational path from keycode to outputs.
- bomb_pulse lasts exactly one frame.
- With BOMB_COOLDOWN=0, a bomb press is accepted on every press edge.
- Key pressed in frame N and released in frame N+1: the command reflects it for exactly the one frame after edge N.

## Configuration
- **KEY_CMD_AUTOFIRE_EN defined:** while the bomb key stays held, a bomb request also fires whenever cooldown=0, with no press edge required. Holding the key therefore repeats set_bomb every BOMB_COOLDOWN+1 frames.
- **KEY_CMD_AUTOFIRE_EN undefined:** only press edges fire, so a held bomb key produces exactly one set_bomb.

## Test plan
- **Reset:** assert Reset mid-frame → command=5, enabled=0, bomb_pulse=0 immediately. After release, keycode0=8'h1A at the next edge → command=0, enabled=1.
- **Last-pressed wins:**
  - frame 1: keycode0=8'h04 (A) → command=2.
  - frame 2: add keycode1=8'h07 (D) → command=3.
  - frame 3: release D → command=2.
  - frame 4: release A → command=5.
- **Same-frame tie:** keycode0=8'h1A (W), keycode1=8'h16 (S) pressed together → command=0. Release W → command=1.
- **Bomb one-shot:** hold keycode0=8'h2C (space) for 20 frames → command=4 and bomb_pulse=1 for exactly one frame, no_op for the rest. With KEY_CMD_AUTOFIRE_EN defined and BOMB_COOLDOWN=8 → pulses at frames 1, 10 and 19.
- **Cooldown drop and bomb-frame priority:** while holding D, press space, release, and press again 3 frames later →
  - first press: command=4, enabled=0 for one frame, then command=3.
  - second press (inside cooldown): ignored, command stays 3.
- **Duplicate and unmapped codes:** keycode0=keycode1=8'h07 → command=3. keycode0=8'h29 → command=5.

Source files
------------

// File: rtl/key_cmd_encoder.sv
// key_cmd_encoder: keyboard keycode pair to registered player command with direction stack and bomb cooldown.
// Define KEY_CMD_AUTOFIRE_EN to repeat bomb requests while the bomb key stays held.
module key_cmd_encoder #(
  parameter logic [7:0] KEY_UP        = 8'h1A,
  parameter logic [7:0] KEY_DOWN      = 8'h16,
  parameter logic [7:0] KEY_LEFT      = 8'h04,
  parameter logic [7:0] KEY_RIGHT     = 8'h07,
  parameter logic [7:0] KEY_BOMB      = 8'h2C,
  parameter int         BOMB_COOLDOWN = 8
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [2:0] command,
  output logic       enabled,
  output logic       bomb_pulse
);
  function automatic logic hit(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] code);
    hit = (code != 8'h00) && ((k0 == code) || (k1 == code));
  endfunction
  logic [4:0]      held, prev_held_q, press, rel;
  logic [3:0]      dir_press, dir_rel;
  logic [3:0][1:0] id_q, id_d;
  logic [3:0]      vld_q, vld_d;
  logic [7:0]      cd_q, cd_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            en_q, en_d, bp_q, fire;
  logic [1:0]      n;
  // Bit order matches direction ids: up=0, down=1, left=2, right=3, bomb=4.
  assign held = {hit(keycode0, keycode1, KEY_BOMB), hit(keycode0, keycode1, KEY_RIGHT),
                 hit(keycode0, keycode1, KEY_LEFT), hit(keycode0, keycode1, KEY_DOWN),
                 hit(keycode0, keycode1, KEY_UP)};
  assign press     = held & ~prev_held_q;
  assign rel       = ~held & prev_held_q;
  assign dir_press = press[3:0];
  assign dir_rel   = rel[3:0];
`ifdef KEY_CMD_AUTOFIRE_EN
  assign fire = held[4] && (cd_q == 8'd0);
`else
  assign fire = press[4] && (cd_q == 8'd0);
`endif
  assign cd_d = fire ? 8'(BOMB_COOLDOWN) : (cd_q != 8'd0) ? cd_q - 8'd1 : 8'd0;
  // Drop released directions keeping order, then push new presses so up lands on top.
  always_comb begin
    id_d  = '0;
    vld_d = '0;
    n     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (vld_q[i] && !dir_rel[id_q[i]]) begin
        id_d[n]  = id_q[i];
        vld_d[n] = 1'b1;
        n        = n + 2'd1;
      end
    end
    for (int d = 3; d >= 0; d--) begin
      if (dir_press[d]) begin
        id_d  = {id_d[2:0], 2'(d)};
        vld_d = {vld_d[2:0], 1'b1};
      end
    end
  end
  // Command chosen from the post-update stack; a firing bomb overrides movement.
  always_comb begin
    cmd_d = fire ? 3'd4 : vld_d[0] ? {1'b0, id_d[0]} : 3'd5;
    en_d  = !fire && vld_d[0];
  end
  // Frame state and registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_held_q <= '0;
      id_q        <= '0;
      vld_q       <= '0;
      cd_q        <= '0;
      cmd_q       <= 3'd5;
      en_q        <= 1'b0;
      bp_q        <= 1'b0;
    end else begin
      prev_held_q <= held;
      id_q        <= id_d;
      vld_q       <= vld_d;
      cd_q        <= cd_d;
      cmd_q       <= cmd_d;
      en_q        <= en_d;
      bp_q        <= fire;
    end
  end
  assign command    = cmd_q;
  assign enabled    = en_q;
  assign bomb_pulse = bp_q;
endmodule

// File: tb/tb_key_cmd_encoder.sv
// tb_key_cmd_encoder: directed checks of key_cmd_encoder outputs packed as {bomb_pulse, enabled, command}.
module tb_key_cmd_encoder;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode0 = 8'h00;
  logic [7:0] keycode1 = 8'h00;
  logic [2:0] command;
  logic       enabled, bomb_pulse;
  int         n_cmp = 0;
  int         n_bad = 0;
  localparam logic [4:0] NOP  = 5'b00_101;
  localparam logic [4:0] BOMB = 5'b10_100;
  localparam logic [4:0] UP   = 5'b01_000;
  localparam logic [4:0] DOWN = 5'b01_001;
  localparam logic [4:0] LEFT = 5'b01_010;
  localparam logic [4:0] RGT  = 5'b01_011;
  key_cmd_encoder dut (
    .Reset(Reset), .frame_clk(frame_clk), .keycode0(keycode0), .keycode1(keycode1),
    .command(command), .enabled(enabled), .bomb_pulse(bomb_pulse)
  );
  always #5 frame_clk = ~frame_clk;
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {bp,en,cmd}=%b expected %b", tag, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] a, input logic [7:0] b, input string tag, input logic [4:0] exp);
    keycode0 = a;
    keycode1 = b;
    @(posedge frame_clk);
    #1;
    chk(tag, {bomb_pulse, enabled, command}, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [4:0] e;
    #12;
    chk("reset_state", {bomb_pulse, enabled, command}, NOP);
    #6 Reset = 1'b0;
    step(8'h1A, 8'h00, "post_reset_up", UP);
    step(8'h2C, 8'h1A, "bomb_over_up", BOMB);
    step(8'h2C, 8'h1A, "up_resumes", UP);
    #3 Reset = 1'b1;
    #1 chk("async_reset", {bomb_pulse, enabled, command}, NOP);
    #2 Reset = 1'b0;
    step(8'h2C, 8'h1A, "cooldown_cleared", BOMB);
    step(8'h00, 8'h00, "idle0", NOP);
    keycode0 = 8'h1A;
    #2 chk("no_comb_path", {bomb_pulse, enabled, command}, NOP);
    step(8'h04, 8'h00, "lp_left", LEFT);
    step(8'h04, 8'h07, "lp_right", RGT);
    step(8'h04, 8'h00, "lp_rel_right", LEFT);
    step(8'h00, 8'h00, "lp_rel_left", NOP);
    step(8'h1A, 8'h16, "tie_up", UP);
    step(8'h00, 8'h16, "tie_rel_up", DOWN);
    step(8'h00, 8'h00, "tie_idle", NOP);
    step(8'h1A, 8'h00, "stk_up", UP);
    step(8'h1A, 8'h04, "stk_left", LEFT);
    step(8'h16, 8'h04, "stk_swap_down", DOWN);
    step(8'h00, 8'h04, "stk_back_left", LEFT);
    step(8'h00, 8'h00, "stk_idle", NOP);
    for (int f = 1; f <= 20; f++) begin
`ifdef KEY_CMD_AUTOFIRE_EN
      e = (f == 1 || f == 10 || f == 19) ? BOMB : NOP;
`else
      e = (f == 1) ? BOMB : NOP;
`endif
      step(8'h2C, 8'h00, $sformatf("bomb_hold_f%0d", f), e);
    end
    for (int f = 0; f < 10; f++) step(8'h00, 8'h00, $sformatf("cool_idle%0d", f), NOP);
    step(8'h07, 8'h00, "cd_right", RGT);
    step(8'h07, 8'h2C, "cd_bomb", BOMB);
    step(8'h07, 8'h00, "cd_resume1", RGT);
    step(8'h07, 8'h00, "cd_resume2", RGT);
    step(8'h07, 8'h2C, "cd_dropped", RGT);
    step(8'h07, 8'h2C, "cd_still_right", RGT);
    step(8'h00, 8'h00, "cd_idle", NOP);
    step(8'h07, 8'h07, "dup_right", RGT);
    step(8'h29, 8'h00, "unmapped", NOP);
    step(8'h00, 8'h16, "slot1_down", DOWN);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
